// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants. FETCH_MISALIGN_CHECK_EN adds the FAULT state.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int OP_W       = 7;
  localparam int FUNCT3_W   = 3;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT7B5   = 30;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
`ifdef FETCH_MISALIGN_CHECK_EN
    DRAIN = 3'd3,
    FAULT = 3'd4
`else
    DRAIN = 3'd3
`endif
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: flush_pc over retire target over hold. With FETCH_MISALIGN_CHECK_EN a
// misaligned new PC is reported instead of being forced to word alignment.
module pc_next
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            retire_i,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            load_o,
  output logic [XLEN-1:0] next_pc_o
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misaligned_o
`endif
);

  logic [XLEN-1:0] raw_pc;

  // Plain modulo-2^32 add, so 32'hFFFF_FFFC wraps to zero.
  assign pc_plus4_o = pc_i + XLEN'(4);
  assign load_o     = flush_i | retire_i;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    raw_pc = pc_i;
    if (flush_i) begin
      raw_pc = flush_pc_i;
    end else if (retire_i) begin
      raw_pc = pc_src_i ? pc_target_i : pc_plus4_o;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign next_pc_o    = raw_pc;
  assign misaligned_o = load_o && (raw_pc[1:0] != 2'b00);
`else
  assign next_pc_o    = raw_pc & ~XLEN'(3);
`endif

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage with decode handshake and flush redirect.
// Optional misaligned-target fault checking under FETCH_MISALIGN_CHECK_EN.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [XLEN-1:0]     instr,
  output logic [OP_W-1:0]     op,
  output logic [FUNCT3_W-1:0] funct3,
  output logic                funct7b5,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  input  logic                PCSrc,
  input  logic [XLEN-1:0]     PCTarget,
  input  logic                flush,
  input  logic [XLEN-1:0]     flush_pc,
  output logic                fetch_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] next_pc;
  logic            retire;
  logic            pc_load;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            fault_q;
  logic            misaligned;
`endif

  assign retire = (state_q == HOLD) && instr_ready;

  pc_next u_pc_next (
    .pc_i        (pc_q),
    .retire_i    (retire),
    .pc_src_i    (PCSrc),
    .pc_target_i (PCTarget),
    .flush_i     (flush),
    .flush_pc_i  (flush_pc),
    .pc_plus4_o  (pc_plus4),
    .load_o      (pc_load),
    .next_pc_o   (next_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misaligned_o(misaligned)
`endif
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: state_d = flush ? FETCH : WAIT;
      WAIT: begin
        if (imem_ack) begin
          // A flushed response is dropped; the old instr stays but is never presented.
          if (!flush) instr_d = imem_rdata;
          state_d = flush ? FETCH : HOLD;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      HOLD:  if (flush || instr_ready) state_d = FETCH;
      DRAIN: if (imem_ack) state_d = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
      FAULT: if (flush) state_d = FETCH;
`endif
      default: state_d = FETCH;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (misaligned) state_d = FAULT;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      if (pc_load) pc_q <= next_pc;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (misaligned) begin
      fault_q <= 1'b1;
    end
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Reset masks the request so memory never sees a fetch during the reset cycle.
  assign imem_req    = !reset && ((state_q == FETCH) || (state_q == WAIT));
  assign imem_addr   = pc_q;
  assign instr_valid = !reset && (state_q == HOLD);

  assign instr    = instr_q;
  assign op       = instr_q[OP_W-1:0];
  assign funct3   = instr_q[FUNCT3_LSB +: FUNCT3_W];
  assign funct7b5 = instr_q[FUNCT7B5];
  assign pc       = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against an
// address-sequence model. Honors FETCH_MISALIGN_CHECK_EN when defined for the whole build.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  // Memory: either an automatic responder or manual strobes from the scenario tasks.
  logic        auto_mode = 1'b0;
  int          mem_delay = 1;
  logic        man_ack   = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        m_ack     = 1'b0;
  logic [31:0] m_rdata   = 32'h0;
  logic        m_busy    = 1'b0;
  int          m_cnt     = 0;
  logic [31:0] m_addr    = 32'h0;

  assign imem_ack   = auto_mode ? m_ack : man_ack;
  assign imem_rdata = auto_mode ? m_rdata : man_rdata;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ack  <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_ack) begin
      m_ack <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_ack   <= 1'b1;
        m_rdata <= mem_word(m_addr);
        m_busy  <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (imem_req) begin
      if (mem_delay <= 1) begin
        m_ack   <= 1'b1;
        m_rdata <= mem_word(imem_addr);
      end else begin
        m_busy <= 1'b1;
        m_cnt  <= mem_delay - 1;
        m_addr <= imem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic use_auto);
    auto_mode   = use_auto;
    mem_delay   = 1;
    reset       = 1'b1;
    flush       = 1'b0;
    flush_pc    = 32'h0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    PCTarget    = 32'h0;
    man_ack     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Current cycle is FETCH: acknowledge in the following WAIT cycle, leave the DUT in HOLD.
  task automatic serve(input logic [31:0] word);
    tick();
    man_ack   = 1'b1;
    man_rdata = word;
    tick();
    man_ack = 1'b0;
  endtask

  task automatic test_reset();
    auto_mode = 1'b0;
    reset     = 1'b1;
    flush     = 1'b1;
    flush_pc  = 32'h500;
    instr_ready = 1'b1;
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req_during: got %0b want 0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_during: got %0b want 0", instr_valid); end
    flush = 1'b0;
    instr_ready = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", pc); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL rst_pc_plus4: got %h want 4", pc_plus4); end
    total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr: got %h want 00000013", instr); end
    total++; if (op !== 7'h13) begin bad++; $display("FAIL rst_op: got %h want 13", op); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", instr_valid); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %0b want 0", fetch_fault); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_first_req: got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    reset_dut(1'b1);
    instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      total++; if (instr_valid !== (i % 3 == 2)) begin bad++; $display("FAIL seq_valid c%0d: got %0b want %0b", i, instr_valid, (i % 3 == 2)); end
      if (i % 3 == 0) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i / 3))) begin bad++; $display("FAIL seq_addr c%0d: got req=%0b addr=%h want 1/%h", i, imem_req, imem_addr, 4 * (i / 3)); end
      end
      if (i % 3 == 2) begin
        total++; if (instr !== mem_word(32'(4 * (i / 3)))) begin bad++; $display("FAIL seq_instr c%0d: got %h want %h", i, instr, mem_word(32'(4 * (i / 3)))); end
      end
      tick();
    end
    instr_ready = 1'b0;
    auto_mode   = 1'b0;
  endtask

  task automatic test_branch();
    reset_dut(1'b0);
    serve(32'h00A0_0063);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL br_valid: got %0b want 1", instr_valid); end
    total++; if (op !== 7'h63 || funct3 !== 3'd0 || funct7b5 !== 1'b0) begin bad++; $display("FAIL br_fields: got op=%h f3=%0d f7b5=%0b want 63/0/0", op, funct3, funct7b5); end
    instr_ready = 1'b1;
    PCSrc       = 1'b1;
    PCTarget    = 32'h40;
    tick();
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL br_target: got req=%0b addr=%h want 1/40", imem_req, imem_addr); end
    total++; if (pc_plus4 !== 32'h44) begin bad++; $display("FAIL br_pc_plus4: got %h want 44", pc_plus4); end
  endtask

  task automatic test_stall();
    reset_dut(1'b0);
    serve(32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      total++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || pc !== 32'h0) begin bad++; $display("FAIL stall_hold c%0d: got v=%0b instr=%h pc=%h want 1/12345678/0", i, instr_valid, instr, pc); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req c%0d: got %0b want 0", i, imem_req); end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin bad++; $display("FAIL stall_release: got req=%0b addr=%h v=%0b want 1/4/0", imem_req, imem_addr, instr_valid); end
  endtask

  task automatic test_flush_wait();
    reset_dut(1'b0);
    tick();
    flush    = 1'b1;
    flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    total++; if (imem_req !== 1'b0 || pc !== 32'h100 || instr_valid !== 1'b0) begin bad++; $display("FAIL fw_drain: got req=%0b pc=%h v=%0b want 0/100/0", imem_req, pc, instr_valid); end
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fw_drain2: got req=%0b want 0", imem_req); end
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin bad++; $display("FAIL fw_refetch: got req=%0b addr=%h v=%0b want 1/100/0", imem_req, imem_addr, instr_valid); end
    serve(32'h0000_0033);
    total++; if (instr !== 32'h0000_0033 || pc !== 32'h100 || instr_valid !== 1'b1) begin bad++; $display("FAIL fw_instr: got instr=%h pc=%h v=%0b want 00000033/100/1", instr, pc, instr_valid); end
  endtask

  task automatic test_flush_ack();
    reset_dut(1'b0);
    tick();
    flush     = 1'b1;
    flush_pc  = 32'h200;
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    flush   = 1'b0;
    man_ack = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin bad++; $display("FAIL fa_refetch: got req=%0b addr=%h v=%0b want 1/200/0", imem_req, imem_addr, instr_valid); end
    serve(32'h0040_0093);
    total++; if (instr !== 32'h0040_0093 || pc !== 32'h200) begin bad++; $display("FAIL fa_instr: got instr=%h pc=%h want 00400093/200", instr, pc); end
  endtask

  task automatic test_flush_hold();
    reset_dut(1'b0);
    serve(32'h0000_006F);
    instr_ready = 1'b1;
    PCSrc       = 1'b1;
    PCTarget    = 32'h40;
    flush       = 1'b1;
    flush_pc    = 32'h300;
    tick();
    flush       = 1'b0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin bad++; $display("FAIL fh_override: got req=%0b addr=%h v=%0b want 1/300/0", imem_req, imem_addr, instr_valid); end
`ifndef FETCH_MISALIGN_CHECK_EN
    flush    = 1'b1;
    flush_pc = 32'h103;
    tick();
    flush = 1'b0;
    total++; if (imem_addr !== 32'h100 || fetch_fault !== 1'b0) begin bad++; $display("FAIL fh_align: got addr=%h fault=%0b want 100/0", imem_addr, fetch_fault); end
`endif
  endtask

  task automatic test_ack_ignored();
    reset_dut(1'b0);
    man_ack   = 1'b1;
    man_rdata = 32'hBAD0_0001;
    tick();
    man_ack = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL ig_fetch: got v=%0b req=%0b want 0/1", instr_valid, imem_req); end
    tick();
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL ig_wait: got v=%0b req=%0b want 0/1", instr_valid, imem_req); end
    man_ack   = 1'b1;
    man_rdata = 32'h0010_0113;
    tick();
    man_rdata = 32'hBAD0_0002;
    tick();
    man_ack = 1'b0;
    total++; if (instr !== 32'h0010_0113 || instr_valid !== 1'b1) begin bad++; $display("FAIL ig_hold: got instr=%h v=%0b want 00100113/1", instr, instr_valid); end
  endtask

  task automatic test_wrap();
    reset_dut(1'b0);
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin bad++; $display("FAIL wr_top: got addr=%h p4=%h want fffffffc/0", imem_addr, pc_plus4); end
    serve(32'h0000_0013);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL wr_wrap: got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
    serve(32'h0000_0067);
    instr_ready = 1'b1;
    PCSrc       = 1'b1;
    PCTarget    = 32'h42;
    tick();
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      total++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL wr_fault c%0d: got fault=%0b req=%0b v=%0b want 1/0/0", i, fetch_fault, imem_req, instr_valid); end
      tick();
    end
    flush    = 1'b1;
    flush_pc = 32'h80;
    tick();
    flush = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || fetch_fault !== 1'b1) begin bad++; $display("FAIL wr_recover: got req=%0b addr=%h fault=%0b want 1/80/1", imem_req, imem_addr, fetch_fault); end
`else
    total++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL wr_align: got fault=%0b req=%0b addr=%h want 0/1/40", fetch_fault, imem_req, imem_addr); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    reset_dut(1'b0);
    flush    = 1'b1;
    flush_pc = 32'h600;
    tick();
    flush = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h600) begin bad++; $display("FAIL rw_wait: got req=%0b addr=%h want 1/600", imem_req, imem_addr); end
    reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rw_req_masked: got %0b want 0", imem_req); end
    tick();
    reset = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rw_restart: got req=%0b addr=%h v=%0b want 1/0/0", imem_req, imem_addr, instr_valid); end
  endtask

  // Model: the stream of fetch addresses is the program-order PC sequence; each retired word
  // must be the memory word at the PC being retired.
  task automatic test_random();
    logic [31:0] exp_pc;
    int          retires;
    reset_dut(1'b1);
    exp_pc  = 32'h0;
    retires = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (imem_req) begin
        total++; if (imem_addr !== exp_pc) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, imem_addr, exp_pc); end
      end
      instr_ready = 1'($urandom_range(0, 1));
      PCSrc       = ($urandom_range(0, 3) == 0);
      PCTarget    = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if (instr_valid) begin
        total++; if (instr !== mem_word(exp_pc) || pc !== exp_pc) begin bad++; $display("FAIL rnd_instr c%0d: got instr=%h pc=%h want %h/%h", cyc, instr, pc, mem_word(exp_pc), exp_pc); end
        if (instr_ready) begin
          exp_pc    = PCSrc ? PCTarget : exp_pc + 32'd4;
          retires++;
          mem_delay = $urandom_range(1, 3);
        end
      end
      tick();
    end
    total++; if (retires < 40) begin bad++; $display("FAIL rnd_progress: got %0d retires want >= 40", retires); end
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    auto_mode   = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    PCTarget    = 32'h0;
    flush       = 1'b0;
    flush_pc    = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_flush_wait();
    test_flush_ack();
    test_flush_hold();
    test_ack_ignored();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Ports: clk  in  1  single clock; all state changes on the rising edge.
REQ-003 Ports: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: imem_req  out  1  fetch request to instruction memory; imem_addr  out  32  byte address of the request.
REQ-005 Ports: imem_ack  in  1  memory response strobe; imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-006 Ports: instr_valid  out  1  instruction held for decode; instr_ready  in  1  decode accepts the instruction.
REQ-007 Ports: instr  out  32  held word; op  out  7  = instr[6:0]; funct3  out  3  = instr[14:12]; funct7b5  out  1  = instr[30].
REQ-008 Ports: pc  out  32  address of instr; pc_plus4  out  32  pc+4.
REQ-009 Ports: PCSrc  in  1  redirect select from control, sampled only on retire; PCTarget  in  32  branch/jump target.
REQ-010 Ports: flush  in  1  asynchronous-to-pipeline redirect (trap/debug); flush_pc  in  32  flush target.
REQ-011 Ports: fetch_fault  out  1  misaligned-target fault (see Configuration).

Function
REQ-012 States SHALL be FETCH, WAIT, HOLD, DRAIN, FAULT.
REQ-013 FETCH: imem_req=1, imem_addr=pc; next state WAIT.
REQ-014 WAIT: imem_req=1, imem_addr=pc held stable; on imem_ack capture imem_rdata into instr, go HOLD.
REQ-015 HOLD: instr_valid=1, instr/pc stable until instr_valid&instr_ready (retire).
REQ-016 On retire: pc <= PCSrc ? PCTarget : pc+4; state FETCH next cycle.
REQ-017 Latency: instr_valid rises the cycle after imem_ack; min 3 cycles per instruction with single-cycle-ack memory.
REQ-018 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 imem_ack outside WAIT/DRAIN SHALL be ignored.
REQ-020 flush in FETCH or HOLD: pc <= flush_pc, instr_valid=0 next cycle, state FETCH; flush overrides a same-cycle retire.
REQ-021 flush in WAIT without imem_ack: pc <= flush_pc, state DRAIN (one response outstanding).
REQ-022 flush in WAIT with imem_ack same cycle: data discarded, pc <= flush_pc, state FETCH.
REQ-023 DRAIN: imem_req=0; on imem_ack discard data, go FETCH; flush in DRAIN updates pc, stays DRAIN.
REQ-024 instr_valid SHALL be 0 in all states except HOLD.

Reset
REQ-025 reset SHALL override every input; next edge: state FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0 that cycle, fetch_fault=0.
REQ-026 Reset mid-WAIT abandons the request; instruction memory is reset by the same reset.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHECK_EN.
REQ-028 Defined: a new pc (retire or flush) with [1:0]!=2'b00 sets fetch_fault (sticky), state FAULT, imem_req=0; only reset or an aligned flush leaves FAULT.
REQ-029 Undefined: new pc bits [1:0] forced to 2'b00, fetch_fault tied 0, FAULT state absent.

Structure
REQ-030 Shared package riscv_pkg SHALL hold the fetch state enum, NOP constant 32'h0000_0013 and field-width constants.
REQ-031 Sub-module pc_next SHALL compute next pc (pc+4 / PCTarget / flush_pc priority, alignment handling).

Verification
REQ-032 Reset, ack 1 cycle after each req, instr_ready=1 -> imem_addr 0,4,8; instr_valid 1 cycle in 3.
REQ-033 Retire 32'h00A0_0063 with PCSrc=1, PCTarget=32'h40 -> next imem_addr 32'h40; op=7'h63, funct3=0.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> instr, pc, instr_valid stable; no imem_req.
REQ-035 flush, flush_pc=32'h100 in WAIT, ack 2 cycles later with 32'hDEAD_BEEF -> word discarded, next imem_addr 32'h100.
REQ-036 pc=32'hFFFF_FFFC retire PCSrc=0 -> next imem_addr 32'h0; with macro, PCTarget=32'h42 -> fetch_fault=1, imem_req=0.
